sram_to_sram_write: RTL and testbench
=====================================

SRAM_TO_SRAM_WRITE -- requirements
Module: sram_to_sram_write

Interface
REQ-001 Parameters SHALL be: ADDR_BITS 10, address width; DATA_BITS 8, signed element width; UNIT_LEN 64, elements per word.
REQ-002 Clock and reset SHALL be: reset, synchronous, active-high; clock clk.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cke  in  1  clock enable; all state holds when low
- start  in  1  arm a transfer
- op  in  2  0 add-sat, 1 sub-sat (data0-data1), 2 max, 3 min; sampled on accepted start
- s_addr  in  ADDR_BITS  element-word address from read stage
- s_data0  in  UNIT_LEN x DATA_BITS  operand A
- s_data1  in  UNIT_LEN x DATA_BITS  operand B
- s_valid  in  1  input word valid (no backpressure)
- mem_wen  out  1  destination SRAM write enable
- mem_waddr  out  ADDR_BITS  write address
- mem_wdata  out  UNIT_LEN x DATA_BITS  write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky address-sequence error

Function
REQ-004 FSM SHALL have states IDLE, RUN, FLUSH; all transitions occur only on cke-high edges.
REQ-005 IDLE->RUN SHALL occur on start=1; op is latched and the expected-address counter and err are cleared to 0.
REQ-006 start SHALL be ignored in RUN and FLUSH.
REQ-007 s_valid SHALL be accepted only in RUN; s_valid in IDLE or FLUSH SHALL be dropped with no write.
REQ-008 Each accepted word SHALL pass through two register stages: operand capture, then result. mem_wen SHALL assert exactly 2 cke-cycles after the cycle in which s_valid was sampled.
REQ-009 Per element, add/sub SHALL compute at DATA_BITS+1 bits and clamp to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1]. Max/min SHALL be signed comparisons.
REQ-010 mem_waddr SHALL equal the s_addr of the same word, delayed 2 stages.
REQ-011 On each accepted word, s_addr SHALL be compared to the expected counter. A mismatch SHALL set err, which stays set until the next accepted start. The counter SHALL increment modulo 2^ADDR_BITS.
REQ-012 Accepting s_addr = all-ones SHALL move RUN->FLUSH.
REQ-013 In FLUSH, the FSM SHALL wait until the final write has issued, then go to IDLE with done=1 for exactly one cycle. The last mem_wen and done SHALL be on consecutive cycles.
REQ-014 busy SHALL be 1 in RUN and FLUSH, and 0 in IDLE.
REQ-015 Back-to-back s_valid SHALL sustain one write per cke-cycle with no bubbles.
REQ-016 With cke=0, mem_wen, done and every register SHALL hold their value.

Reset
REQ-017 On reset, the FSM SHALL go to IDLE, and mem_wen, busy, done and err SHALL be 0. Data and address pipeline registers need not be reset.
REQ-018 Reset mid-transfer SHALL abort it: no mem_wen after the reset edge, and no done.
REQ-019 Reset SHALL take priority over cke.

Structure
REQ-020 A shared package SHALL hold the op enum (OP_ADD, OP_SUB, OP_MAX, OP_MIN) and the FSM state typedef. The addr_t and data_t type parameters SHALL follow the read stage.
REQ-021 The per-element arithmetic SHALL be a single sub-module, sram_to_sram_alu_elem, instantiated UNIT_LEN times. It is combinational; the enclosing block registers its outputs.

Verification
REQ-022 op=0, one element 100+50, all others 1+1 -> written 127 and 2. Element -100+-50 -> -128.
REQ-023 op=1, 0-(-128) -> 127. op=2 (-5,3) -> 3. op=3 (-5,3) -> -5.
REQ-024 start, then 1024 consecutive words (addr 0..1023) with s_valid held -> 1024 writes, mem_wen 2 cycles after each s_valid, done one cycle after the last write, err=0.
REQ-025 Address sequence 0,1,3 -> err=1 from the cycle after addr 3 is sampled, held through done; cleared by the next start.
REQ-026 cke toggled 50% during a run -> identical write sequence, stretched in time; no duplicate or lost writes.
REQ-027 reset asserted after 10 words -> mem_wen=0 from the next cycle, no done, busy=0; a subsequent start runs normally.

Source files
------------

// File: rtl/sram_to_sram_write_pkg.sv
// Shared types for the SRAM-to-SRAM write stage.
//   op_e    : per-element operation selected when a transfer starts
//   state_e : control FSM states of the write stage
//   addr_t / data_t : default address and signed element types, matching
//                     the read stage that feeds this block
package sram_to_sram_write_pkg;

  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_UNIT_LEN  = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MAX = 2'd2,
    OP_MIN = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef logic        [DEF_ADDR_BITS-1:0] addr_t;
  typedef logic signed [DEF_DATA_BITS-1:0] data_t;

endpackage

// File: rtl/sram_to_sram_alu_elem.sv
// Combinational per-element operator for the SRAM-to-SRAM write stage.
// Ports:
//   op : operation (saturating add, saturating sub a-b, signed max, signed min)
//   a  : signed operand A
//   b  : signed operand B
//   y  : signed result, saturated to the DATA_BITS range for add/sub
module sram_to_sram_alu_elem
  import sram_to_sram_write_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  op_e                         op,
  input  logic signed [DATA_BITS-1:0] a,
  input  logic signed [DATA_BITS-1:0] b,
  output logic signed [DATA_BITS-1:0] y
);

  // One guard bit is enough for a+b or a-b; overflow shows as the guard bit
  // disagreeing with the narrow sign bit.
  function automatic logic signed [DATA_BITS-1:0] sat_narrow(
    input logic signed [DATA_BITS:0] v
  );
    if (v[DATA_BITS] != v[DATA_BITS-1]) begin
      if (v[DATA_BITS]) return {1'b1, {(DATA_BITS-1){1'b0}}};
      else              return {1'b0, {(DATA_BITS-1){1'b1}}};
    end
    return v[DATA_BITS-1:0];
  endfunction

  logic signed [DATA_BITS:0] a_ext;
  logic signed [DATA_BITS:0] b_ext;

  assign a_ext = {a[DATA_BITS-1], a};
  assign b_ext = {b[DATA_BITS-1], b};

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = sat_narrow(a_ext + b_ext);
      OP_SUB:  y = sat_narrow(a_ext - b_ext);
      OP_MAX:  y = (a > b) ? a : b;
      OP_MIN:  y = (a < b) ? a : b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/sram_to_sram_write.sv
// SRAM-to-SRAM write stage: combines two operand words element-wise and
// writes the result to the destination SRAM two cycles after acceptance.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   cke             : clock enable, all state holds while low
//   start, op       : arm a transfer and select its operation
//   s_addr          : word address from the read stage
//   s_data0/s_data1 : operand words A and B (UNIT_LEN signed elements)
//   s_valid         : input word valid (no backpressure)
//   mem_wen/waddr/wdata : destination SRAM write port
//   busy            : transfer in progress (RUN or FLUSH)
//   done            : one-cycle pulse after the final write
//   err             : sticky address-sequence error, cleared on start
module sram_to_sram_write
  import sram_to_sram_write_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int UNIT_LEN  = DEF_UNIT_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cke,
  input  logic                          start,
  input  logic [1:0]                    op,
  input  logic [ADDR_BITS-1:0]          s_addr,
  input  logic [UNIT_LEN*DATA_BITS-1:0] s_data0,
  input  logic [UNIT_LEN*DATA_BITS-1:0] s_data1,
  input  logic                          s_valid,
  output logic                          mem_wen,
  output logic [ADDR_BITS-1:0]          mem_waddr,
  output logic [UNIT_LEN*DATA_BITS-1:0] mem_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  state_e                 state_q, state_d;
  op_e                    op_q;
  logic [ADDR_BITS-1:0]   exp_addr_q;
  logic                   err_q;
  logic                   done_q, done_d;
  logic                   start_acc;
  logic                   accept;

  logic                   vld_p0, vld_p1;
  logic [ADDR_BITS-1:0]   addr_p0, addr_p1;
  logic signed [DATA_BITS-1:0] a_p0 [UNIT_LEN];
  logic signed [DATA_BITS-1:0] b_p0 [UNIT_LEN];
  logic signed [DATA_BITS-1:0] alu_y [UNIT_LEN];
  logic [UNIT_LEN*DATA_BITS-1:0] wdata_p1;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    start_acc = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (s_valid) begin
          accept = 1'b1;
          if (&s_addr) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // The last word has left the capture stage, so the write port is
        // issuing it this cycle; done lands on the following cycle.
        if (!vld_p0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      exp_addr_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
    end else if (cke) begin
      state_q <= state_d;
      done_q  <= done_d;
      vld_p0  <= accept;
      vld_p1  <= vld_p0;
      if (start_acc) begin
        op_q       <= op_e'(op);
        exp_addr_q <= '0;
        err_q      <= 1'b0;
      end else if (accept) begin
        exp_addr_q <= exp_addr_q + 1'b1;
        if (s_addr != exp_addr_q) err_q <= 1'b1;
      end
    end
  end

  // ---- stage p0: operand capture ----
  always_ff @(posedge clk) begin
    if (cke && accept) begin
      addr_p0 <= s_addr;
      for (int i = 0; i < UNIT_LEN; i++) begin
        a_p0[i] <= s_data0[i*DATA_BITS +: DATA_BITS];
        b_p0[i] <= s_data1[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  for (genvar g = 0; g < UNIT_LEN; g++) begin : g_elem
    sram_to_sram_alu_elem #(
      .DATA_BITS(DATA_BITS)
    ) u_alu (
      .op(op_q),
      .a (a_p0[g]),
      .b (b_p0[g]),
      .y (alu_y[g])
    );
  end

  // ---- stage p1: result register feeding the write port ----
  always_ff @(posedge clk) begin
    if (cke && vld_p0) begin
      addr_p1 <= addr_p0;
      for (int i = 0; i < UNIT_LEN; i++) begin
        wdata_p1[i*DATA_BITS +: DATA_BITS] <= alu_y[i];
      end
    end
  end

  assign mem_wen   = vld_p1;
  assign mem_waddr = addr_p1;
  assign mem_wdata = wdata_p1;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sram_to_sram_write.sv
// Scoreboard bench for sram_to_sram_write: the driver pushes each expected
// write (address, data, cke-cycle it must appear in); a monitor on the
// falling edge pops and compares every write the DUT issues.
module tb_sram_to_sram_write;
  import sram_to_sram_write_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int UL = 64;
  localparam int WW = DW * UL;

  logic          clk = 1'b0;
  logic          reset, cke, start, s_valid;
  logic [1:0]    op;
  logic [AW-1:0] s_addr;
  logic [WW-1:0] s_data0, s_data1;
  logic          mem_wen, busy, done, err;
  logic [AW-1:0] mem_waddr;
  logic [WW-1:0] mem_wdata;

  always #5 clk = ~clk;

  sram_to_sram_write #(.ADDR_BITS(AW), .DATA_BITS(DW), .UNIT_LEN(UL)) dut (
    .clk(clk), .reset(reset), .cke(cke), .start(start), .op(op),
    .s_addr(s_addr), .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   kcyc = 0;
  int   last_wr_cyc = -1;
  logic cke_ph = 1'b0;

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %b want %b", name, act, exp); end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin bad++; $display("FAIL %s: got %0d want %0d", name, act, exp); end
  endtask

  task automatic check_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %0d want %0d", name, act, exp); end
  endtask

  task automatic check_v(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %0h want %0h", name, act, exp); end
  endtask

  // cke-cycle counter: number of enabled edges seen so far
  always @(posedge clk) if (cke === 1'b1) kcyc <= kcyc + 1;

  // Monitor: a write counts when mem_wen is high in a cycle whose edge is enabled
  always @(negedge clk) begin
    if (mem_wen === 1'b1 && cke === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_b("unexpected_write", 1'b1, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        check_a("waddr", mem_waddr, mon_e.addr);
        check_v("wdata", mem_wdata, mon_e.data);
        check_i("wcycle", kcyc, mon_e.cyc);
      end
      last_wr_cyc = kcyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [WW-1:0] build(input int e0, input int e1, input int er);
    logic [WW-1:0] w;
    for (int i = 0; i < UL; i++) w[i*DW +: DW] = DW'(er);
    w[0 +: DW]  = DW'(e0);
    w[DW +: DW] = DW'(e1);
    return w;
  endfunction

  function automatic logic [WW-1:0] pat(input int addr, input int salt);
    logic [WW-1:0] w;
    for (int i = 0; i < UL; i++) w[i*DW +: DW] = DW'(addr * salt + i * 37 + salt * 11);
    return w;
  endfunction

  function automatic logic [WW-1:0] ref_word(input int o, input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic [WW-1:0] w;
    int x, y, r;
    for (int i = 0; i < UL; i++) begin
      x = int'($signed(a[i*DW +: DW]));
      y = int'($signed(b[i*DW +: DW]));
      case (o)
        0:       r = x + y;
        1:       r = x - y;
        2:       r = (x > y) ? x : y;
        default: r = (x < y) ? x : y;
      endcase
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      w[i*DW +: DW] = DW'(r);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] addr, input logic [WW-1:0] a,
                      input logic [WW-1:0] b, input logic [WW-1:0] e, input bit push);
    s_valid = 1'b1; s_addr = addr; s_data0 = a; s_data1 = b;
    if (push && cke === 1'b1) sb_q.push_back('{addr: addr, data: e, cyc: kcyc + 2});
    tick();
  endtask

  // Holds the word until an enabled cycle takes it, cke alternating each cycle
  task automatic send_cke(input logic [AW-1:0] addr, input logic [WW-1:0] a,
                          input logic [WW-1:0] b, input logic [WW-1:0] e);
    bit sent = 1'b0;
    while (!sent) begin
      cke_ph = ~cke_ph;
      cke = cke_ph;
      if (cke_ph) sent = 1'b1;
      send(addr, a, b, e, 1'b1);
    end
  endtask

  task automatic do_start(input logic [1:0] o);
    cke = 1'b1; s_valid = 1'b0; start = 1'b1; op = o;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input logic err_exp);
    int n = 0;
    s_valid = 1'b0; cke = 1'b1;
    while (done !== 1'b1 && n < 16) begin tick(); n++; end
    if (done !== 1'b1) begin
      check_b("done_timeout", done, 1'b1);
    end else begin
      check_i("done_latency", kcyc, last_wr_cyc + 1);
      check_b("done_busy", busy, 1'b0);
      check_b("done_err", err, err_exp);
      check_i("sb_empty", sb_q.size(), 0);
      tick();
      check_b("done_pulse", done, 1'b0);
    end
  endtask

  // Single word at the last address: one write, err set (counter expected 0),
  // and a follow-up word presented in FLUSH that must be dropped.
  task automatic run_single(input logic [1:0] o, input logic [WW-1:0] a,
                            input logic [WW-1:0] b, input logic [WW-1:0] e);
    do_start(o);
    check_b("run_busy", busy, 1'b1);
    check_b("run_err_clr", err, 1'b0);
    send(10'd1023, a, b, e, 1'b1);
    start = 1'b1; op = 2'd3;
    send(10'd0, b, a, '0, 1'b0);
    start = 1'b0;
    wait_done(1'b1);
  endtask

  initial begin
    reset = 1'b1; cke = 1'b0; start = 1'b0; op = 2'd0; s_valid = 1'b0;
    s_addr = '0; s_data0 = '0; s_data1 = '0;
    repeat (3) tick();
    check_b("rst_mem_wen", mem_wen, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_done", done, 1'b0);
    check_b("rst_err", err, 1'b0);
    reset = 1'b0; cke = 1'b1;

    // words in IDLE are dropped
    send(10'd5, pat(5, 3), pat(5, 7), '0, 1'b0);
    send(10'd1023, pat(6, 3), pat(6, 7), '0, 1'b0);
    s_valid = 1'b0;
    tick(); tick();
    check_b("idle_busy", busy, 1'b0);

    // directed element arithmetic
    run_single(2'd0, build(100, -100, 1), build(50, -50, 1), build(127, -128, 2));
    run_single(2'd1, build(0, -128, 5), build(-128, 1, 3), build(127, -128, 2));
    run_single(2'd2, build(-5, 3, 7), build(3, -5, -8), build(3, 3, 7));
    run_single(2'd3, build(-5, 3, 7), build(3, -5, -8), build(-5, -5, -8));

    // full 1024-word run, back to back; start pulses mid-run must be ignored
    do_start(2'd0);
    for (int a = 0; a < 1024; a++) begin
      start = (a % 100 == 50); op = 2'd1;
      send(AW'(a), pat(a, 3), pat(a, 5), ref_word(0, pat(a, 3), pat(a, 5)), 1'b1);
    end
    start = 1'b0;
    wait_done(1'b0);

    // address sequence 0,1,3 -> err
    do_start(2'd0);
    send(10'd0, pat(0, 9), pat(0, 2), ref_word(0, pat(0, 9), pat(0, 2)), 1'b1);
    send(10'd1, pat(1, 9), pat(1, 2), ref_word(0, pat(1, 9), pat(1, 2)), 1'b1);
    check_b("seq_err_before", err, 1'b0);
    send(10'd3, pat(3, 9), pat(3, 2), ref_word(0, pat(3, 9), pat(3, 2)), 1'b1);
    check_b("seq_err_after", err, 1'b1);
    send(10'd1023, pat(4, 9), pat(4, 2), ref_word(0, pat(4, 9), pat(4, 2)), 1'b1);
    wait_done(1'b1);
    do_start(2'd1);
    check_b("seq_err_cleared", err, 1'b0);

    // reset after 10 words: word 8 still writes, word 9 is lost
    for (int a = 0; a < 10; a++)
      send(AW'(a), pat(a, 4), pat(a, 6), ref_word(1, pat(a, 4), pat(a, 6)), 1'b1);
    s_valid = 1'b0; reset = 1'b1;
    tick();
    check_i("rst_pending", sb_q.size(), 1);
    sb_q.delete();
    check_b("rst_mid_wen", mem_wen, 1'b0);
    check_b("rst_mid_busy", busy, 1'b0);
    check_b("rst_mid_err", err, 1'b0);
    reset = 1'b0;
    repeat (4) begin
      check_b("rst_no_done", done, 1'b0);
      check_b("rst_no_wen", mem_wen, 1'b0);
      tick();
    end
    run_single(2'd0, build(100, -100, 1), build(50, -50, 1), build(127, -128, 2));

    // cke toggling every cycle, max op
    do_start(2'd2);
    for (int a = 0; a < 1024; a++)
      send_cke(AW'(a), pat(a, 7), pat(a, 13), ref_word(2, pat(a, 7), pat(a, 13)));
    wait_done(1'b0);

    check_i("final_sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
